// File: rtl/riscv_dmem_responder_if.sv
// riscv_dmem_responder_if: core data-memory bus (addr, wdata, byte write-enable, rdata)
//   master: core side, drives addr/wdata/we, receives rdata
//   slave:  responder side, samples addr/wdata/we, returns rdata two edges later
interface riscv_dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  modport master(output addr, wdata, we, input rdata);
  modport slave(input addr, wdata, we, output rdata);
endinterface

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: data-memory responder with BRAM words and an LED/switch/cycle-counter MMIO window
//   clk_in   single clock
//   rst_in   synchronous active-high reset
//   bus      slave side of the core data bus; every cycle is a read, nonzero we also writes
//   sw_in    board switches (asynchronous), read at MMIO +0x4 through a 2-flop synchronizer
//   led_out  LED register, written at MMIO +0x0 via byte lanes 0 and 1
module riscv_dmem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  riscv_dmem_responder_if.slave  bus,
  input  logic [15:0]            sw_in,
  output logic [15:0]            led_out
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q, mmio_q, mmio_rd, hi_snap;
  logic [63:0] cycle_q;
  logic [15:0] sw_meta, sw_sync;
  logic        v1, mmio1, is_mmio, unused_bits;
  logic [1:0]  off;
  logic [AW-1:0] idx;
  assign is_mmio = bus.addr[31] == MMIO_BASE[31];
  assign off = bus.addr[3:2];
  assign idx = bus.addr[AW+1:2];
  // Upper address bits alias the RAM and byte offsets are the core's concern.
  assign unused_bits = ^{bus.addr[30:AW+2], bus.addr[1:0]};
  always_comb mmio_rd = off == 2'd0 ? {16'b0, led_out} :
                        off == 2'd1 ? {16'b0, sw_sync} :
                        off == 2'd2 ? cycle_q[31:0] : hi_snap;
  // Unreset BRAM port: read-first, so a same-word write shows up on the following read.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 4; i++)
      if (!rst_in && !is_mmio && bus.we[i]) ram[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
    ram_q <= ram[idx];
  end
  // v1 marks stage 1 as holding a post-reset access, so stale BRAM output never escapes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1 <= 1'b0;
      mmio1 <= 1'b0;
      mmio_q <= '0;
      bus.rdata <= '0;
      led_out <= '0;
      cycle_q <= '0;
      hi_snap <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      v1 <= 1'b1;
      mmio1 <= is_mmio;
      mmio_q <= mmio_rd;
      bus.rdata <= v1 ? (mmio1 ? mmio_q : ram_q) : 32'h0;
      cycle_q <= cycle_q + 64'd1;
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (is_mmio && off == 2'd2) hi_snap <= cycle_q[63:32];
      if (is_mmio && off == 2'd0 && bus.we[0]) led_out[7:0] <= bus.wdata[7:0];
      if (is_mmio && off == 2'd0 && bus.we[1]) led_out[15:8] <= bus.wdata[15:8];
    end
  end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// tb_riscv_dmem_responder: random + directed stimulus checked against a transaction-level memory/MMIO model
module tb_riscv_dmem_responder;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  riscv_dmem_responder_if bus();
  riscv_dmem_responder dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus.slave),
    .sw_in(sw_in),
    .led_out(led_out)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [31:0] exp;
    bit          chk;
  } item_t;
  item_t       q[$];
  item_t       cmp_it;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [int];
  logic [15:0] m_led = '0;
  logic [63:0] m_cyc = '0;
  logic [31:0] m_hi = '0;
  logic [15:0] next_sw = '0;
  bit          frozen = 0;
  int          sw_age = 0;
  logic [31:0] e;
  // Result of the access sampled two edges ago is visible just after the latest edge.
  always @(posedge clk_in) begin
    #1;
    if (q.size() > 0) begin
      checks++;
      if (led_out !== m_led) begin
        errors++;
        $display("FAIL led_out got %h want %h at %0t", led_out, m_led, $time);
      end
    end
    if (q.size() >= 2) begin
      cmp_it = q.pop_front();
      if (cmp_it.chk) begin
        checks++;
        if (bus.rdata !== cmp_it.exp) begin
          errors++;
          $display("FAIL rdata got %h want %h at %0t", bus.rdata, cmp_it.exp, $time);
        end
      end
    end
  end
  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  // One bus cycle: drive inputs, predict the read result, then apply the write to the model.
  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                      output logic [31:0] ex);
    item_t it;
    int key;
    @(negedge clk_in);
    rst_in = r;
    bus.addr = a;
    bus.wdata = d;
    bus.we = w;
    if (sw_in != next_sw) begin
      sw_in = next_sw;
      sw_age = 0;
    end
    it.chk = 1;
    it.exp = '0;
    if (r) begin
      if (q.size() > 0) q[$].exp = '0;
      m_led = '0;
      m_cyc = '0;
      m_hi = '0;
      sw_age = 0;
    end else begin
      if (a[31]) begin
        case (a[3:2])
          2'd0: it.exp = {16'b0, m_led};
          2'd1: begin it.exp = {16'b0, sw_in}; it.chk = sw_age >= 3; end
          2'd2: begin it.exp = m_cyc[31:0]; m_hi = m_cyc[63:32]; end
          default: it.exp = m_hi;
        endcase
        if (a[3:2] == 2'd0 && w[0]) m_led[7:0] = d[7:0];
        if (a[3:2] == 2'd0 && w[1]) m_led[15:8] = d[15:8];
      end else begin
        key = int'((a >> 2) % 4096);
        if (mem.exists(key)) begin
          it.exp = mem[key];
          for (int i = 0; i < 4; i++) if (w[i]) mem[key][8*i +: 8] = d[8*i +: 8];
        end else begin
          it.chk = 0;
          if (w == 4'hF) mem[key] = d;
        end
      end
      if (!frozen) m_cyc++;
      sw_age++;
    end
    q.push_back(it);
    ex = it.exp;
  endtask
  initial begin
    bus.addr = '0;
    bus.wdata = '0;
    bus.we = '0;
    for (int i = 0; i < 3; i++) step(1, 32'h0, 32'h0, 4'h0, e);
    step(0, 32'h100, 32'h0, 4'hF, e);
    step(0, 32'h100, 32'hDEAD_BEEF, 4'hF, e);
    pin("rd_before_write", e, 32'h0);
    step(0, 32'h100, 32'h0, 4'h0, e);
    pin("rd_after_write", e, 32'hDEAD_BEEF);
    step(0, 32'h40, 32'h1122_3344, 4'hF, e);
    step(0, 32'h40, 32'hAABB_CCDD, 4'b0101, e);
    step(0, 32'h40, 32'h0, 4'h0, e);
    pin("byte_lanes", e, 32'h11BB_33DD);
    step(0, 32'h80, 32'h5, 4'hF, e);
    step(0, 32'h80, 32'h9, 4'hF, e);
    pin("read_first", e, 32'h5);
    step(0, 32'h80, 32'h0, 4'h0, e);
    pin("next_read", e, 32'h9);
    step(0, 32'h0, 32'h7, 4'hF, e);
    step(0, 32'h4000, 32'h0, 4'h0, e);
    pin("wrap", e, 32'h7);
    step(0, 32'h8000_0000, 32'hFFFF_1234, 4'hF, e);
    step(0, 32'h8000_0000, 32'h0, 4'h0, e);
    pin("led_read", e, 32'h0000_1234);
    pin("led_model", {16'b0, m_led}, 32'h0000_1234);
    next_sw = 16'hA5A5;
    for (int i = 0; i < 4; i++) step(0, 32'h8000_0004, 32'h0, 4'hF, e);
    pin("sw_read", e, 32'h0000_A5A5);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    m_cyc = 64'h0000_0000_FFFF_FFFE;
    frozen = 1;
    step(0, 32'h8000_0008, 32'h0, 4'h0, e);
    pin("cycle_lo", e, 32'hFFFF_FFFE);
    step(0, 32'h8000_000C, 32'h0, 4'h0, e);
    pin("cycle_hi", e, 32'h0);
    step(0, 32'h100, 32'h0, 4'h0, e);
    release dut.cycle_q;
    frozen = 0;
    step(1, 32'h100, 32'h1234_5678, 4'hF, e);
    step(1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF, e);
    pin("led_reset", {16'b0, m_led}, 32'h0);
    step(0, 32'h8000_0008, 32'h0, 4'h0, e);
    pin("cycle_restart", e, 32'h0);
    step(0, 32'h8000_0008, 32'h0, 4'h0, e);
    pin("cycle_inc", e, 32'h1);
    step(0, 32'h100, 32'h0, 4'h0, e);
    pin("reset_write_dropped", e, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++) step(0, 32'(i) << 2, $urandom, 4'hF, e);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      if ($urandom_range(49) == 0) next_sw = 16'($urandom);
      if ($urandom_range(9) < 7) a = ($urandom & 32'h7FFF_C000) | (32'($urandom_range(16)) << 2) | ($urandom & 32'h3);
      else a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
      w = $urandom_range(1) ? 4'($urandom) : 4'h0;
      step($urandom_range(199) == 0, a, $urandom, w, e);
    end
    for (int i = 0; i < 3; i++) step(0, 32'h100, 32'h0, 4'h0, e);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
